// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size codes
// and default timeout.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      FAULT
   } lsu_state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

   function automatic logic is_illegal(input logic load_req, input logic store_req,
                                       input logic [2:0] fun3);
      logic bad;
      bad = 1'b0;
      if (load_req && store_req) begin
         bad = 1'b1;
      end else if (load_req) begin
         bad = (fun3 == 3'b011) || (fun3 == 3'b110) || (fun3 == 3'b111);
      end else if (store_req) begin
         bad = (fun3 > SW);
      end
      return bad;
   endfunction

   // A half-word may straddle bytes 1..2, but never cross into the next word.
   function automatic logic is_misaligned(input logic [2:0] fun3, input logic [1:0] offset);
      return ((fun3[1:0] == 2'b01) && (offset == 2'b11)) ||
             ((fun3[1:0] == 2'b10) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enables and data placement, load
// byte/half extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  logic [2:0]           fun3,
   input  logic [1:0]           offset,
   input  logic [DataWidth-1:0] store_data,
   input  logic [DataWidth-1:0] rdata,
   output logic [3:0]           mask,
   output logic [DataWidth-1:0] wdata,
   output logic [DataWidth-1:0] load_data
);

   logic [DataWidth-1:0] shifted;

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      mask      = 4'b0000;
      wdata     = store_data;
      load_data = rdata;
      shifted   = rdata >> {offset, 3'b000};
      case (fun3[1:0])
         2'b00: begin
            mask      = 4'b0001 << offset;
            wdata     = {(DataWidth/8){store_data[7:0]}};
            load_data = fun3[2] ? {{(DataWidth-8){1'b0}}, shifted[7:0]}
                                : {{(DataWidth-8){shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            mask      = 4'b0011 << offset;
            wdata     = DataWidth'(store_data[15:0]) << {offset, 3'b000};
            load_data = fun3[2] ? {{(DataWidth-16){1'b0}}, shifted[15:0]}
                                : {{(DataWidth-16){shifted[15]}}, shifted[15:0]};
         end
         2'b10: begin
            mask      = 4'b1111;
            wdata     = store_data;
            load_data = rdata;
         end
         default: begin
            mask = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// Load/store unit controller: one outstanding memory access, request/grant
// handshake, read timeout, misalign and illegal-request fault reporting.
module lsu_controller
   import lsu_pkg::*;
#(
   parameter int DataWidth     = 32,
   parameter int TimeoutCycles = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_req,
   input  logic                 store_req,
   input  logic [2:0]           fun3,
   input  logic [DataWidth-1:0] addr,
   input  logic [DataWidth-1:0] store_data,
   output logic                 stall_o,
   output logic                 load_valid_o,
   output logic [DataWidth-1:0] load_data_o,
   output logic                 misalign_o,
   output logic                 err_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [DataWidth-1:0] mem_addr_o,
   output logic [3:0]           mem_mask_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [DataWidth-1:0] mem_rdata_i
);

   localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

   lsu_state_e           state_q, state_d;
   logic [DataWidth-1:0] addr_q, store_data_q, load_data_q;
   logic [2:0]           fun3_q;
   logic                 is_load_q, fault_misalign_q;
   logic [7:0]           cnt_q;

   logic                 any_req, one_req, illegal, misaligned, rdata_take;
   logic [3:0]           align_mask;
   logic [DataWidth-1:0] align_wdata, align_load;

   assign any_req    = load_req | store_req;
   assign one_req    = load_req ^ store_req;
   assign illegal    = is_illegal(load_req, store_req, fun3);
   assign misaligned = is_misaligned(fun3, addr[1:0]);

   // Read data is only meaningful for a load, in the grant cycle or while waiting.
   assign rdata_take = is_load_q && mem_rvalid_i &&
                       (((state_q == REQ) && mem_gnt_i) || (state_q == WAIT));

   lsu_align #(.DataWidth(DataWidth)) u_align (
      .fun3       (fun3_q),
      .offset     (addr_q[1:0]),
      .store_data (store_data_q),
      .rdata      (mem_rdata_i),
      .mask       (align_mask),
      .wdata      (align_wdata),
      .load_data  (align_load)
   );

   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall_o = any_req;
            if (any_req) begin
               state_d = (illegal || misaligned) ? FAULT : REQ;
            end
         end
         REQ: begin
            stall_o = 1'b1;
            if (mem_gnt_i) begin
               if (!is_load_q || mem_rvalid_i) state_d = DONE;
               else                            state_d = WAIT;
            end
         end
         WAIT: begin
            stall_o = 1'b1;
            if (mem_rvalid_i)               state_d = DONE;
            else if (cnt_q == TimeoutLast)  state_d = FAULT;
         end
         DONE:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         addr_q           <= '0;
         store_data_q     <= '0;
         fun3_q           <= '0;
         is_load_q        <= 1'b0;
         fault_misalign_q <= 1'b0;
         cnt_q            <= '0;
         load_data_q      <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && any_req) begin
            fault_misalign_q <= !illegal && misaligned;
            if (one_req) begin
               addr_q       <= addr;
               store_data_q <= store_data;
               fun3_q       <= fun3;
               is_load_q    <= load_req;
            end
         end
         if ((state_d == WAIT) && (state_q != WAIT)) cnt_q <= '0;
         else if (state_q == WAIT)                   cnt_q <= cnt_q + 8'd1;
         if (rdata_take) load_data_q <= align_load;
      end
   end

   assign mem_req_o    = (state_q == REQ);
   assign mem_we_o     = (state_q == REQ) && !is_load_q;
   assign mem_addr_o   = {addr_q[DataWidth-1:2], 2'b00};
   assign mem_mask_o   = (state_q == REQ) ? align_mask : 4'b0000;
   assign mem_wdata_o  = align_wdata;
   assign load_valid_o = (state_q == DONE) && is_load_q;
   assign load_data_o  = load_data_q;
   assign misalign_o   = (state_q == FAULT) && fault_misalign_q;
   assign err_o        = (state_q == FAULT) && !fault_misalign_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed self-checking bench for lsu_controller with a memory-transaction
// and load-result scoreboard.
module tb_lsu_controller;
   import lsu_pkg::*;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } mem_txn_t;

   logic        clk, rst_n;
   logic        load_req, store_req;
   logic [2:0]  fun3;
   logic [31:0] addr, store_data;
   logic        stall_o, load_valid_o, misalign_o, err_o;
   logic [31:0] load_data_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_mask_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   mem_txn_t    exp_mem[$];
   logic [31:0] exp_load[$];
   logic [31:0] last_ld;
   int          n_total = 0;
   int          n_pass  = 0;
   int          n_fail  = 0;

   lsu_controller #(.DataWidth(32), .TimeoutCycles(255)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_req     (load_req),
      .store_req    (store_req),
      .fun3         (fun3),
      .addr         (addr),
      .store_data   (store_data),
      .stall_o      (stall_o),
      .load_valid_o (load_valid_o),
      .load_data_o  (load_data_o),
      .misalign_o   (misalign_o),
      .err_o        (err_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_mask_o   (mem_mask_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] expand(input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
      return r;
   endfunction

   // One legal access; gnt_wait = REQ cycles before grant, rv_wait = WAIT cycles (0: rvalid with grant).
   task automatic access(input logic is_load, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int gnt_wait,
                         input int rv_wait, input logic [3:0] emask, input logic [31:0] ewdata,
                         input logic [31:0] eld);
      int       stalls;
      mem_txn_t t;
      stalls = 0;
      exp_mem.push_back('{we: !is_load, addr: {a[31:2], 2'b00}, mask: emask, wdata: ewdata});
      if (is_load) exp_load.push_back(eld);
      @(posedge clk); #1;
      load_req = is_load; store_req = !is_load; fun3 = f3; addr = a; store_data = sd;
      mem_rdata_i = rd;
      @(negedge clk); if (stall_o) stalls++;
      @(posedge clk); #1;
      load_req = 1'b0; store_req = 1'b0;
      for (int i = 0; i < gnt_wait; i++) begin
         @(negedge clk); if (stall_o) stalls++;
         check("req_held", {31'd0, mem_req_o}, 32'd1);
         @(posedge clk); #1;
      end
      mem_gnt_i = 1'b1;
      mem_rvalid_i = is_load && (rv_wait == 0);
      @(negedge clk); if (stall_o) stalls++;
      t = exp_mem.pop_front();
      check("mem_req", {31'd0, mem_req_o}, 32'd1);
      check("mem_we", {31'd0, mem_we_o}, {31'd0, t.we});
      check("mem_addr", mem_addr_o, t.addr);
      check("mem_mask", {28'd0, mem_mask_o}, {28'd0, t.mask});
      if (t.we) check("mem_wdata", mem_wdata_o & expand(t.mask), t.wdata);
      @(posedge clk); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      if (is_load && rv_wait > 0) begin
         for (int i = 0; i < rv_wait - 1; i++) begin
            @(negedge clk); if (stall_o) stalls++;
            @(posedge clk); #1;
         end
         mem_rvalid_i = 1'b1;
         @(negedge clk); if (stall_o) stalls++;
         @(posedge clk); #1;
         mem_rvalid_i = 1'b0;
      end
      @(negedge clk); if (stall_o) stalls++;
      check("stall_cycles", stalls, 2 + gnt_wait + ((is_load && rv_wait > 0) ? rv_wait : 0));
      check("load_valid", {31'd0, load_valid_o}, {31'd0, is_load});
      if (load_valid_o && exp_load.size() > 0) begin
         last_ld = exp_load.pop_front();
         check("load_data", load_data_o, last_ld);
      end else if (is_load && exp_load.size() > 0) begin
         last_ld = exp_load.pop_front();
      end
      @(posedge clk); #1;
   endtask

   task automatic fault(input logic lr, input logic sr, input logic [2:0] f3,
                        input logic [31:0] a, input logic exp_mis);
      @(posedge clk); #1;
      load_req = lr; store_req = sr; fun3 = f3; addr = a;
      @(negedge clk);
      check("fault_stall_idle", {31'd0, stall_o}, 32'd1);
      @(posedge clk); #1;
      load_req = 1'b0; store_req = 1'b0;
      @(negedge clk);
      check("fault_misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
      check("fault_err", {31'd0, err_o}, {31'd0, !exp_mis});
      check("fault_no_req", {30'd0, mem_req_o, stall_o}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("fault_pulse_end", {29'd0, misalign_o, err_o, mem_req_o}, 32'd0);
   endtask

   initial begin
      int waits;
      int reqs;
      rst_n = 1'b0; load_req = 1'b0; store_req = 1'b0; fun3 = 3'b000;
      addr = '0; store_data = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      last_ld = '0;
      #12;
      check("rst_outputs", {27'd0, stall_o, load_valid_o, misalign_o, err_o, mem_req_o}, 32'd0);
      check("rst_mask", {28'd0, mem_mask_o}, 32'd0);
      check("rst_load_data", load_data_o, 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // sw: grant after two REQ cycles, stall for three cycles.
      access(1'b0, SW, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, 4'b1111, 32'hDEADBEEF, 32'h0);

      // Stray rvalid in IDLE must not disturb the load result.
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
      @(negedge clk);
      check("idle_rvalid_valid", {31'd0, load_valid_o}, 32'd0);
      check("idle_rvalid_data", load_data_o, last_ld);
      @(posedge clk); #1 mem_rvalid_i = 1'b0;

      access(1'b1, LB,  32'h103, 32'h0, 32'h80AA5511, 0, 2, 4'b1000, 32'h0, 32'hFFFFFF80);
      access(1'b1, LH,  32'h101, 32'h0, 32'h12ABCD34, 0, 0, 4'b0110, 32'h0, 32'hFFFFABCD);
      access(1'b0, SB,  32'h102, 32'h000000A5, 32'h0, 0, 0, 4'b0100, 32'h00A50000, 32'h0);
      access(1'b0, SH,  32'h101, 32'hFFFF1234, 32'h0, 2, 0, 4'b0110, 32'h00123400, 32'h0);
      access(1'b1, LHU, 32'h102, 32'h0, 32'h80017F00, 0, 1, 4'b1100, 32'h0, 32'h00008001);
      access(1'b1, LW,  32'h104, 32'h0, 32'h13579BDF, 2, 3, 4'b1111, 32'h0, 32'h13579BDF);

      fault(1'b1, 1'b0, LW, 32'h102, 1'b1);
      fault(1'b0, 1'b1, SH, 32'h103, 1'b1);
      fault(1'b1, 1'b1, LW, 32'h100, 1'b0);
      fault(1'b1, 1'b0, 3'b011, 32'h100, 1'b0);
      fault(1'b0, 1'b1, 3'b100, 32'h100, 1'b0);

      // Held request with instant grant: one store every three cycles.
      reqs = 0;
      @(posedge clk); #1;
      store_req = 1'b1; fun3 = SW; addr = 32'h300; store_data = 32'h01020304; mem_gnt_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); if (mem_req_o) reqs++;
      end
      check("back_to_back_reqs", reqs, 2);
      @(posedge clk); #1 store_req = 1'b0; mem_gnt_i = 1'b0;

      // Load that never gets rvalid times out after 255 WAIT cycles.
      @(posedge clk); #1;
      load_req = 1'b1; fun3 = LW; addr = 32'h200;
      @(posedge clk); #1;
      load_req = 1'b0; mem_gnt_i = 1'b1;
      @(posedge clk); #1;
      mem_gnt_i = 1'b0;
      waits = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (err_o || !stall_o) break;
         waits++;
      end
      check("timeout_wait_cycles", waits, 255);
      check("timeout_err", {31'd0, err_o}, 32'd1);
      check("timeout_no_valid", {30'd0, load_valid_o, stall_o}, 32'd0);
      check("timeout_data_held", load_data_o, last_ld);
      @(posedge clk); #1;
      @(negedge clk);
      check("timeout_idle", {30'd0, err_o, stall_o}, 32'd0);

      // Reset while waiting for read data abandons the access silently.
      @(posedge clk); #1;
      load_req = 1'b1; fun3 = LH; addr = 32'h104;
      @(posedge clk); #1;
      load_req = 1'b0; mem_gnt_i = 1'b1;
      @(posedge clk); #1;
      mem_gnt_i = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("wait_stall_before_rst", {31'd0, stall_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_req_stall", {30'd0, mem_req_o, stall_o}, 32'd0);
      check("rst_mid_pulses", {30'd0, load_valid_o, err_o}, 32'd0);
      check("rst_mid_load_data", load_data_o, 32'd0);
      last_ld = '0;
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_quiet", {29'd0, err_o, load_valid_o, stall_o}, 32'd0);

      access(1'b1, LBU, 32'h103, 32'h0, 32'h80AA5511, 0, 1, 4'b1000, 32'h0, 32'h00000080);

      check("scoreboard_empty", exp_mem.size() + exp_load.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 Parameters SHALL be: DataWidth, default 32, data/address width; TimeoutCycles, default 255, maximum wait for mem_rvalid_i, counted by an 8-bit counter.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock, rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit, the reset: asynchronous, active-low.
REQ-004 Core-side inputs SHALL be: load_req 1 (load request); store_req 1 (store request); fun3 3 (access size/sign); addr DataWidth (byte address); store_data DataWidth (rs2 value).
REQ-005 Core-side outputs SHALL be: stall_o 1 (hold pipeline); load_valid_o 1 (load result valid, one-cycle pulse); load_data_o DataWidth (extended load result); misalign_o 1 (misalign pulse); err_o 1 (illegal-request or timeout pulse).
REQ-006 Memory-side outputs SHALL be: mem_req_o 1; mem_we_o 1; mem_addr_o DataWidth (addr with [1:0] forced to 00); mem_mask_o 4 (byte enables); mem_wdata_o DataWidth (lane-steered data).
REQ-007 Memory-side inputs SHALL be: mem_gnt_i 1 (request accepted); mem_rvalid_i 1 (read data valid); mem_rdata_i DataWidth.

Function
REQ-008 The FSM SHALL have the states IDLE, REQ, WAIT, DONE and FAULT.
REQ-009 In IDLE, a request with exactly one of load_req/store_req high SHALL capture addr, fun3 and store_data into registers on that edge.
REQ-010 IDLE exit, legal request: go to REQ. Misaligned request: go to FAULT with misalign_o. Illegal request: go to FAULT with err_o.
REQ-011 Misaligned SHALL mean: half-word with addr[1:0]=11, or word with addr[1:0]!=00. A half-word at offset 01 SHALL be legal.
REQ-012 Illegal SHALL mean: load_req and store_req high together; load fun3 in {011,110,111}; store fun3 above 010. No memory transaction SHALL occur for an illegal request.
REQ-013 In REQ, mem_req_o SHALL stay high with stable addr/mask/wdata/we until mem_gnt_i.
REQ-014 On grant, a store SHALL go to DONE. A load SHALL go to WAIT, or straight to DONE if mem_rvalid_i is high in the grant cycle.
REQ-015 In WAIT, a load SHALL capture mem_rdata_i on mem_rvalid_i and go to DONE.
REQ-016 mem_rvalid_i outside REQ/WAIT SHALL be ignored.
REQ-017 The timeout counter SHALL clear on entering WAIT and increment each WAIT cycle. When it reaches TimeoutCycles, the FSM SHALL go to FAULT with err_o and load_valid_o SHALL stay low.
REQ-018 DONE SHALL last one cycle and then return to IDLE. load_valid_o SHALL pulse in DONE for loads only.
REQ-019 FAULT SHALL last one cycle and then return to IDLE. The misalign_o/err_o pulse SHALL be asserted in FAULT.
REQ-020 stall_o SHALL be high combinationally in IDLE while any request is present, and in REQ and WAIT. It SHALL be low in DONE, FAULT and idle-without-request.
REQ-021 Store mask/data (mask, lane value): sb 0001/0010/0100/1000 with the byte replicated into lane addr[1:0]; sh 0011/0110/1100 with the half placed at lane addr[1:0]; sw 1111 with data unchanged.
REQ-022 Load extraction: lb/lbu select byte addr[1:0]; lh/lhu select bytes [addr+1:addr]; lw passes the word. lb/lh sign-extend; lbu/lhu zero-extend.
REQ-023 load_data_o SHALL hold its last value until the next load completes.
REQ-024 A new request SHALL only be accepted in IDLE. Requests arriving in DONE or FAULT SHALL be accepted on the following IDLE cycle, giving a back-to-back throughput of one access per 3 cycles minimum.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, drop mem_req_o, and clear all registered outputs, the counter and the capture registers to 0.
REQ-026 Reset mid-transaction SHALL abandon the access, with no load_valid_o and no err_o.

Structure
REQ-027 Package lsu_pkg SHALL hold the FSM state enum, fun3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the default TimeoutCycles.
REQ-028 Sub-module lsu_align SHALL be the only child: purely combinational store lane steering, mask generation and load extraction/extension.
REQ-029 The controller SHALL hold all sequential logic.

Verification
REQ-030 sw addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> mem_mask_o 1111, mem_addr_o 0x100, stall_o high 3 cycles then low, no load_valid_o.
REQ-031 lb addr 0x103, rdata 0x80AA5511 -> load_data_o 0xFFFFFF80. lbu at the same address -> 0x00000080.
REQ-032 lh addr 0x101, rdata 0x12ABCD34 -> load_data_o 0xFFFFABCD. Same-cycle gnt+rvalid -> DONE one cycle after REQ.
REQ-033 lw addr 0x102 -> misalign_o pulse, mem_req_o never high. load_req and store_req together -> err_o pulse.
REQ-034 Load with no rvalid for 255 WAIT cycles -> err_o pulse, return to IDLE, stall_o low.
REQ-035 rst_n low during WAIT -> mem_req_o/stall_o 0 immediately, and the next load completes normally.
